// File: rtl/jtframe_dump_pkg.sv
// Shared encodings for the dump-window sequencer: FSM states and trigger modes.
package jtframe_dump_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_DL    = 3'd1,
        ST_WAIT_FRAME = 3'd2,
        ST_DUMP       = 3'd3,
        ST_DONE       = 3'd4
    } dump_state_t;

    localparam logic MODE_FRAME = 1'b0;
    localparam logic MODE_DL    = 1'b1;

endpackage

// File: rtl/jtframe_edge_sync.sv
// Optional two-flop synchronizer followed by a registered falling-edge strobe.
module jtframe_edge_sync #(
    parameter int SYNC = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic fall
);

    logic w_in;
    logic r_last;
    logic r_fall;

    generate
        if (SYNC != 0) begin : g_sync
            logic r_s1;
            logic r_s2;
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_s1 <= 1'b0;
                    r_s2 <= 1'b0;
                end else begin
                    r_s1 <= din;
                    r_s2 <= r_s1;
                end
            end
            assign w_in = r_s2;
        end else begin : g_nosync
            assign w_in = din;
        end
    endgenerate

    // Strobe is registered so downstream logic sees a clean single-cycle pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_last <= w_in;
            r_fall <= r_last & ~w_in;
        end
    end

    assign fall = r_fall;

endmodule

// File: rtl/jtframe_dump_ctrl.sv
// Dump-window sequencer: counts frames and opens/closes the dump window on a
// frame-number or download-end trigger.
module jtframe_dump_ctrl
    import jtframe_dump_pkg::*;
#(
    parameter int SYNC    = 1,
    parameter int HOLDOFF = 20000,
    parameter int HW      = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vs,
    input  logic        led,
    input  logic        arm,
    input  logic        abort,
    input  logic        mode,
    input  logic [31:0] start_frame,
    input  logic [15:0] len,
    output logic [31:0] frame_cnt,
    output logic        dump_on,
    output logic        dump_start,
    output logic        dump_stop,
    output logic [2:0]  st
);

    logic          w_vs_fall;
    logic          w_led_fall;
    logic          w_hold_ok;
    logic          w_enter;
    logic          w_tick;
    logic          w_last;

    logic [HW-1:0] r_hold;
    logic [31:0]   r_frame_cnt;
    dump_state_t   r_st;
    logic          r_mode;
    logic [31:0]   r_start;
    logic [15:0]   r_len;
    logic [15:0]   r_rem;
    logic          r_on;
    logic          r_dstart;
    logic          r_dstop;

    jtframe_edge_sync #(.SYNC(SYNC)) u_vs_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (vs),
        .fall  (w_vs_fall)
    );

    jtframe_edge_sync #(.SYNC(SYNC)) u_led_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (led),
        .fall  (w_led_fall)
    );

    assign w_hold_ok = (r_hold == HW'(HOLDOFF));

    // Trigger compares the frame number before this fall's increment lands
    assign w_enter = !abort &&
                     (((r_st == ST_WAIT_DL) && w_led_fall && w_hold_ok) ||
                      ((r_st == ST_WAIT_FRAME) && w_vs_fall && (r_frame_cnt == r_start)));
    assign w_tick  = !abort && (r_st == ST_DUMP) && w_vs_fall && (r_len != 16'd0);
    assign w_last  = w_tick && (r_rem == 16'd1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hold      <= '0;
            r_frame_cnt <= 32'd0;
        end else begin
            if (!w_hold_ok)
                r_hold <= r_hold + 1'b1;
            if (w_vs_fall)
                r_frame_cnt <= r_frame_cnt + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_st     <= ST_IDLE;
            r_on     <= 1'b0;
            r_dstart <= 1'b0;
            r_dstop  <= 1'b0;
        end else begin
            r_dstart <= 1'b0;
            r_dstop  <= 1'b0;
            if (abort) begin
                r_st    <= ST_IDLE;
                r_on    <= 1'b0;
                r_dstop <= (r_st == ST_DUMP);
            end else begin
                case (r_st)
                    ST_IDLE: begin
                        if (arm)
                            r_st <= (mode == MODE_DL) ? ST_WAIT_DL : ST_WAIT_FRAME;
                    end
                    ST_WAIT_DL, ST_WAIT_FRAME: begin
                        if (w_enter) begin
                            r_st     <= ST_DUMP;
                            r_on     <= 1'b1;
                            r_dstart <= 1'b1;
                        end
                    end
                    ST_DUMP: begin
                        if (w_last) begin
                            r_st    <= ST_DONE;
                            r_on    <= 1'b0;
                            r_dstop <= 1'b1;
                        end
                    end
                    ST_DONE: begin
                        if (!arm)
                            r_st <= ST_IDLE;
                    end
                    default: r_st <= ST_IDLE;
                endcase
            end
        end
    end

    // Configuration and frame budget are data-only; their validity follows r_st
    always_ff @(posedge clk) begin
        if (!abort && (r_st == ST_IDLE) && arm) begin
            r_mode  <= mode;
            r_start <= start_frame;
            r_len   <= len;
        end
        if (w_enter)
            r_rem <= r_len;
        else if (w_tick && !w_last)
            r_rem <= r_rem - 16'd1;
    end

    assign frame_cnt  = r_frame_cnt;
    assign dump_on    = r_on;
    assign dump_start = r_dstart;
    assign dump_stop  = r_dstop;
    assign st         = r_st;

endmodule

// File: tb/tb_jtframe_dump_ctrl.sv
// Self-checking bench for jtframe_dump_ctrl: scenario tasks against a frame-level model.
module tb_jtframe_dump_ctrl;

    localparam logic [2:0] S_IDLE = 3'd0, S_WDL = 3'd1, S_WFR = 3'd2, S_DUMP = 3'd3, S_DONE = 3'd4;
    // led/vs sampled on the first edge, then 3 more edges until dump_start is visible
    localparam int TRIG_LAT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vs = 1'b0;
    logic        led = 1'b0;
    logic        arm = 1'b0;
    logic        abort = 1'b0;
    logic        mode = 1'b0;
    logic [31:0] start_frame = 32'd0;
    logic [15:0] len = 16'd0;
    logic [31:0] frame_cnt;
    logic        dump_on;
    logic        dump_start;
    logic        dump_stop;
    logic [2:0]  st;

    int checks = 0;
    int errors = 0;
    int n_start = 0, n_stop = 0, n_both = 0;
    logic [31:0] fc_at_start = 0, fc_at_stop = 0;
    logic [2:0]  st_at_stop = 0;

    always #5 clk = ~clk;

    jtframe_dump_ctrl #(.SYNC(1), .HOLDOFF(100), .HW(16)) dut (
        .clk(clk), .rst_n(rst_n), .vs(vs), .led(led), .arm(arm), .abort(abort),
        .mode(mode), .start_frame(start_frame), .len(len), .frame_cnt(frame_cnt),
        .dump_on(dump_on), .dump_start(dump_start), .dump_stop(dump_stop), .st(st)
    );

    always @(negedge clk) begin
        if (dump_start) begin n_start++; fc_at_start = frame_cnt; end
        if (dump_stop) begin n_stop++; fc_at_stop = frame_cnt; st_at_stop = st; end
        if (dump_start && dump_stop) n_both++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        vs = 1'b0; arm = 1'b0; abort = 1'b0;
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
    endtask

    task automatic frame();
        vs = 1'b1;
        tick($urandom_range(1, 3));
        vs = 1'b0;
        tick($urandom_range(6, 9));
    endtask

    task automatic arm_pulse(input logic m, input logic [31:0] s, input logic [15:0] l);
        mode = m; start_frame = s; len = l; arm = 1'b1;
        tick(1);
        arm = 1'b0;
    endtask

    task automatic test_reset();
        led = 1'b0;
        do_reset();
        checks++; if (frame_cnt !== 32'd0) begin errors++; $display("FAIL reset_fc: got %0d want 0", frame_cnt); end
        checks++; if (dump_on !== 1'b0) begin errors++; $display("FAIL reset_on: got %b want 0", dump_on); end
        checks++; if (dump_start !== 1'b0) begin errors++; $display("FAIL reset_start: got %b want 0", dump_start); end
        checks++; if (dump_stop !== 1'b0) begin errors++; $display("FAIL reset_stop: got %b want 0", dump_stop); end
        checks++; if (st !== S_IDLE) begin errors++; $display("FAIL reset_st: got %0d want %0d", st, S_IDLE); end
    endtask

    task automatic test_frame_trigger();
        int bs, bp;
        logic exp_on;
        do_reset();
        bs = n_start; bp = n_stop;
        arm_pulse(1'b0, 32'd5, 16'd3);
        // cfg changes after arming must not matter
        start_frame = 32'd1; len = 16'd0;
        checks++; if (st !== S_WFR) begin errors++; $display("FAIL ft_st_wait: got %0d want %0d", st, S_WFR); end
        for (int k = 0; k < 10; k++) begin
            frame();
            exp_on = (k >= 5 && k < 8);
            checks++; if (dump_on !== exp_on) begin errors++; $display("FAIL ft_on frame %0d: got %b want %b", k, dump_on, exp_on); end
        end
        checks++; if (n_start - bs !== 1) begin errors++; $display("FAIL ft_nstart: got %0d want 1", n_start - bs); end
        checks++; if (n_stop - bp !== 1) begin errors++; $display("FAIL ft_nstop: got %0d want 1", n_stop - bp); end
        checks++; if (fc_at_start !== 32'd6) begin errors++; $display("FAIL ft_fc_start: got %0d want 6", fc_at_start); end
        checks++; if (fc_at_stop !== 32'd9) begin errors++; $display("FAIL ft_fc_stop: got %0d want 9", fc_at_stop); end
        checks++; if (st_at_stop !== S_DONE) begin errors++; $display("FAIL ft_st_stop: got %0d want %0d", st_at_stop, S_DONE); end
        checks++; if (frame_cnt !== 32'd10) begin errors++; $display("FAIL ft_fc_end: got %0d want 10", frame_cnt); end
        checks++; if (st !== S_IDLE) begin errors++; $display("FAIL ft_st_end: got %0d want %0d", st, S_IDLE); end
    endtask

    task automatic test_dl_trigger();
        int bs, lat;
        led = 1'b1;
        do_reset();
        bs = n_start;
        arm_pulse(1'b1, 32'd0, 16'd0);
        checks++; if (st !== S_WDL) begin errors++; $display("FAIL dl_st_wait: got %0d want %0d", st, S_WDL); end
        vs = 1'b1; tick(2); vs = 1'b0; tick(6);
        checks++; if (frame_cnt !== 32'd1) begin errors++; $display("FAIL dl_fc: got %0d want 1", frame_cnt); end
        checks++; if (st !== S_WDL) begin errors++; $display("FAIL dl_st_vs: got %0d want %0d", st, S_WDL); end
        tick(41);
        led = 1'b0;
        tick(10);
        checks++; if (st !== S_WDL) begin errors++; $display("FAIL dl_holdoff_st: got %0d want %0d", st, S_WDL); end
        checks++; if (n_start - bs !== 0) begin errors++; $display("FAIL dl_holdoff_start: got %0d want 0", n_start - bs); end
        led = 1'b1;
        tick(240);
        led = 1'b0;
        lat = 0;
        while (!dump_start && lat < 20) begin tick(1); lat++; end
        checks++; if (lat !== TRIG_LAT) begin errors++; $display("FAIL dl_latency: got %0d want %0d", lat, TRIG_LAT); end
        checks++; if (st !== S_DUMP) begin errors++; $display("FAIL dl_st_dump: got %0d want %0d", st, S_DUMP); end
        checks++; if (dump_on !== 1'b1) begin errors++; $display("FAIL dl_on: got %b want 1", dump_on); end
        abort = 1'b1; tick(1); abort = 1'b0;
        checks++; if (dump_stop !== 1'b1) begin errors++; $display("FAIL dl_abort_stop: got %b want 1", dump_stop); end
        checks++; if (st !== S_IDLE) begin errors++; $display("FAIL dl_abort_st: got %0d want %0d", st, S_IDLE); end
        tick(1);
        checks++; if (dump_stop !== 1'b0) begin errors++; $display("FAIL dl_stop_width: got %b want 0", dump_stop); end
    endtask

    task automatic test_unlimited();
        int bp;
        logic exp_on;
        led = 1'b0;
        do_reset();
        bp = n_stop;
        arm_pulse(1'b0, 32'd2, 16'd0);
        for (int k = 0; k < 53; k++) begin
            frame();
            exp_on = (k >= 2);
            checks++; if (dump_on !== exp_on) begin errors++; $display("FAIL un_on frame %0d: got %b want %b", k, dump_on, exp_on); end
        end
        checks++; if (n_stop - bp !== 0) begin errors++; $display("FAIL un_nstop: got %0d want 0", n_stop - bp); end
        abort = 1'b1; tick(1); abort = 1'b0;
        checks++; if (dump_stop !== 1'b1) begin errors++; $display("FAIL un_abort_stop: got %b want 1", dump_stop); end
        checks++; if (dump_on !== 1'b0) begin errors++; $display("FAIL un_abort_on: got %b want 0", dump_on); end
        checks++; if (st !== S_IDLE) begin errors++; $display("FAIL un_abort_st: got %0d want %0d", st, S_IDLE); end
    endtask

    task automatic test_rearm();
        int bs;
        do_reset();
        bs = n_start;
        mode = 1'b0; start_frame = 32'd1; len = 16'd2; arm = 1'b1;
        for (int k = 0; k < 5; k++) frame();
        checks++; if (st !== S_DONE) begin errors++; $display("FAIL ra_st_done: got %0d want %0d", st, S_DONE); end
        checks++; if (n_start - bs !== 1) begin errors++; $display("FAIL ra_nstart1: got %0d want 1", n_start - bs); end
        arm = 1'b0; tick(1);
        checks++; if (st !== S_IDLE) begin errors++; $display("FAIL ra_st_idle: got %0d want %0d", st, S_IDLE); end
        start_frame = frame_cnt + 32'd1; arm = 1'b1; tick(1);
        checks++; if (st !== S_WFR) begin errors++; $display("FAIL ra_st_wait: got %0d want %0d", st, S_WFR); end
        frame(); frame();
        checks++; if (n_start - bs !== 2) begin errors++; $display("FAIL ra_nstart2: got %0d want 2", n_start - bs); end
        checks++; if (dump_on !== 1'b1) begin errors++; $display("FAIL ra_on: got %b want 1", dump_on); end
        arm = 1'b0; abort = 1'b1; tick(1); abort = 1'b0;
    endtask

    task automatic test_abort_race();
        int bs;
        do_reset();
        bs = n_start;
        arm_pulse(1'b0, 32'd1, 16'd2);
        frame();
        vs = 1'b1; tick(2);
        vs = 1'b0; tick(3);
        abort = 1'b1; tick(1); abort = 1'b0;
        tick(4);
        checks++; if (n_start - bs !== 0) begin errors++; $display("FAIL ar_nstart: got %0d want 0", n_start - bs); end
        checks++; if (st !== S_IDLE) begin errors++; $display("FAIL ar_st: got %0d want %0d", st, S_IDLE); end
        checks++; if (frame_cnt !== 32'd2) begin errors++; $display("FAIL ar_fc: got %0d want 2", frame_cnt); end
        checks++; if (dump_on !== 1'b0) begin errors++; $display("FAIL ar_on: got %b want 0", dump_on); end
    endtask

    task automatic test_reset_mid();
        int bp;
        do_reset();
        arm_pulse(1'b0, 32'd0, 16'd0);
        frame();
        checks++; if (dump_on !== 1'b1) begin errors++; $display("FAIL rm_on_before: got %b want 1", dump_on); end
        bp = n_stop;
        rst_n = 1'b0; tick(1); rst_n = 1'b1;
        checks++; if (frame_cnt !== 32'd0) begin errors++; $display("FAIL rm_fc: got %0d want 0", frame_cnt); end
        checks++; if (dump_on !== 1'b0) begin errors++; $display("FAIL rm_on: got %b want 0", dump_on); end
        checks++; if (dump_start !== 1'b0) begin errors++; $display("FAIL rm_start: got %b want 0", dump_start); end
        checks++; if (dump_stop !== 1'b0) begin errors++; $display("FAIL rm_stop: got %b want 0", dump_stop); end
        checks++; if (st !== S_IDLE) begin errors++; $display("FAIL rm_st: got %0d want %0d", st, S_IDLE); end
        tick(2);
        checks++; if (n_stop - bp !== 0) begin errors++; $display("FAIL rm_nstop: got %0d want 0", n_stop - bp); end
    endtask

    task automatic test_random_windows();
        int s, l, nf, bs, bp;
        logic exp_on;
        for (int it = 0; it < 4; it++) begin
            do_reset();
            s = $urandom_range(0, 6);
            l = $urandom_range(1, 4);
            nf = s + l + 3;
            bs = n_start; bp = n_stop;
            arm_pulse(1'b0, 32'(s), 16'(l));
            for (int k = 0; k < nf; k++) begin
                led = 1'($urandom_range(0, 1));
                frame();
                exp_on = (k >= s && k < s + l);
                checks++; if (dump_on !== exp_on) begin errors++; $display("FAIL rnd_on it %0d frame %0d: got %b want %b", it, k, dump_on, exp_on); end
            end
            checks++; if (n_start - bs !== 1) begin errors++; $display("FAIL rnd_nstart it %0d: got %0d want 1", it, n_start - bs); end
            checks++; if (n_stop - bp !== 1) begin errors++; $display("FAIL rnd_nstop it %0d: got %0d want 1", it, n_stop - bp); end
            checks++; if (fc_at_start !== 32'(s + 1)) begin errors++; $display("FAIL rnd_fc_start it %0d: got %0d want %0d", it, fc_at_start, s + 1); end
            checks++; if (fc_at_stop !== 32'(s + l + 1)) begin errors++; $display("FAIL rnd_fc_stop it %0d: got %0d want %0d", it, fc_at_stop, s + l + 1); end
            checks++; if (frame_cnt !== 32'(nf)) begin errors++; $display("FAIL rnd_fc_end it %0d: got %0d want %0d", it, frame_cnt, nf); end
        end
    endtask

    task automatic test_exclusive_pulses();
        checks++; if (n_both !== 0) begin errors++; $display("FAIL start_stop_same_cycle: got %0d want 0", n_both); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_frame_trigger();
        test_dl_trigger();
        test_unlimited();
        test_rearm();
        test_abort_race();
        test_reset_mid();
        test_random_windows();
        test_exclusive_pulses();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
